gcd_driver: RTL and testbench

Initiator-side controller for the subtraction-based GCD engine. It accepts operand pairs on an upstream valid/ready interface and launches each job on the engine's `start`/`done` port. It captures the engine result and presents it on a downstream valid/ready interface, with a watchdog timeout and a completed-job counter. It sits between the host/test sequencer and one GCD engine instance, and the engine's `clk`/`reset_n` are shared with it.

---
 rtl/gcd_driver.sv | 95 +++++++++
 tb/tb_gcd_driver.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gcd_driver.sv
// gcd_driver: hands operand pairs to a GCD engine one job at a time and returns results
// over valid/ready, with a watchdog timeout and a wrapping completed-job counter.
module gcd_driver #(
  parameter int nbits          = 32,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [nbits-1:0] in_a,
  input  logic [nbits-1:0] in_b,
  output logic [nbits-1:0] eng_a,
  output logic [nbits-1:0] eng_b,
  output logic             eng_start,
  input  logic             eng_done,
  input  logic [nbits-1:0] eng_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [nbits-1:0] out_gcd,
  output logic             out_err,
  output logic [CNT_W-1:0] jobs_done
);
  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] LAST = TW'(TIMEOUT_CYCLES - 1);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RESP, DRAIN} state_t;
  state_t           state_q, state_d;
  logic [nbits-1:0] eng_a_q, eng_a_d, eng_b_q, eng_b_d, gcd_q, gcd_d;
  logic             err_q, err_d, late_q, late_d, ready_q, ready_d;
  logic [TW-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0] jobs_q, jobs_d;
  logic             accept, timeout, handshake;
  assign accept    = in_valid & ready_q;
  assign timeout   = cnt_q == LAST;
  assign handshake = (state_q == RESP) & out_ready;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = accept ? ISSUE : IDLE;
      ISSUE:   state_d = WAIT;
      WAIT:    state_d = (eng_done || timeout) ? RESP : WAIT;
      RESP:    state_d = !out_ready ? RESP : err_q ? DRAIN : IDLE;
      DRAIN:   state_d = (eng_done || late_q) ? IDLE : DRAIN;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    eng_start = state_q == ISSUE;
    out_valid = state_q == RESP;
    in_ready  = ready_q;
    eng_a     = eng_a_q;
    eng_b     = eng_b_q;
    out_gcd   = gcd_q;
    out_err   = err_q;
    jobs_done = jobs_q;
  end
  // A late engine completion seen while the timed-out result waits downstream is remembered,
  // so DRAIN does not wait for a pulse that has already gone by.
  always_comb begin
    eng_a_d = accept ? in_a : eng_a_q;
    eng_b_d = accept ? in_b : eng_b_q;
    cnt_d   = state_q == ISSUE ? '0 : state_q == WAIT ? cnt_q + 1'b1 : cnt_q;
    gcd_d   = state_q != WAIT ? gcd_q : eng_done ? eng_result : timeout ? '0 : gcd_q;
    err_d   = state_q != WAIT ? err_q : eng_done ? 1'b0 : timeout ? 1'b1 : err_q;
    jobs_d  = jobs_q + CNT_W'(handshake);
    late_d  = state_q == RESP ? late_q | (err_q & eng_done) : state_q == DRAIN ? 1'b0 : late_q;
    ready_d = state_d == IDLE;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      eng_a_q <= '0;
      eng_b_q <= '0;
      gcd_q   <= '0;
      err_q   <= 1'b0;
      late_q  <= 1'b0;
      ready_q <= 1'b0;
      cnt_q   <= '0;
      jobs_q  <= '0;
    end else begin
      eng_a_q <= eng_a_d;
      eng_b_q <= eng_b_d;
      gcd_q   <= gcd_d;
      err_q   <= err_d;
      late_q  <= late_d;
      ready_q <= ready_d;
      cnt_q   <= cnt_d;
      jobs_q  <= jobs_d;
    end
  end
endmodule

// File: tb/tb_gcd_driver.sv
// tb_gcd_driver: drives gcd_driver against a behavioural engine stub and a queue-based reference model.
module tb_gcd_driver;
  localparam int TO = 16;
  logic        clk = 1'b0, reset_n = 1'b0;
  logic        in_valid = 1'b0, in_ready, eng_start, eng_done, out_valid, out_ready = 1'b1, out_err;
  logic [31:0] in_a = '0, in_b = '0, eng_a, eng_b, eng_result, out_gcd;
  logic [1:0]  jobs_done;
  int          total = 0, bad = 0;
  int          lat = 3, acc_cnt = 0, late_cnt = 0, late_seen = 0, job_lat = 0;
  bit          hang = 0, job_hang = 0;
  logic [32:0] exp_q[$];
  logic [31:0] got_q[$];
  logic [1:0]  exp_jobs = '0;

  gcd_driver #(.nbits(32), .TIMEOUT_CYCLES(TO), .CNT_W(2)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .eng_a(eng_a), .eng_b(eng_b), .eng_start(eng_start),
    .eng_done(eng_done), .eng_result(eng_result), .out_valid(out_valid),
    .out_ready(out_ready), .out_gcd(out_gcd), .out_err(out_err), .jobs_done(jobs_done));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h @%0t", tag, got, want, $time);
    end
  endtask

  function automatic logic [31:0] ref_gcd(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] x = a, y = b, t;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  // Engine stub: answers after job_lat cycles unless the job hangs; late_cnt requests a stray pulse.
  initial begin
    logic [31:0] r;
    eng_done = 1'b0;
    eng_result = '0;
    forever begin
      @(negedge clk);
      if (!reset_n) eng_done = 1'b0;
      else if (late_cnt != late_seen) begin
        late_seen = late_cnt;
        eng_result = 32'hdead_beef;
        eng_done = 1'b1;
        @(negedge clk);
        eng_done = 1'b0;
      end else if (eng_start && !job_hang) begin
        r = ref_gcd(eng_a, eng_b);
        for (int i = 0; i < job_lat && reset_n; i++) @(negedge clk);
        if (reset_n) begin
          eng_result = r;
          eng_done = 1'b1;
          @(negedge clk);
          eng_done = 1'b0;
          eng_result = $urandom;
        end
      end
    end
  end

  // Reference model and protocol monitor, sampled on the falling edge.
  initial begin
    logic [31:0] la = '0, lb = '0, hg = '0;
    logic [32:0] e;
    bit prev_start = 0, held = 0, he = 0, err;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        exp_q.delete();
        exp_jobs = '0;
        prev_start = 0;
        held = 0;
      end else begin
        chk("jobs_done", jobs_done, exp_jobs);
        chk("ready_excl", in_ready & (out_valid | eng_start), 0);
        if (in_valid && in_ready) begin
          job_lat = lat;
          job_hang = hang;
          err = hang || lat > TO;
          exp_q.push_back({err, err ? 32'd0 : ref_gcd(in_a, in_b)});
          la = in_a;
          lb = in_b;
          acc_cnt++;
        end
        if (eng_start) begin
          chk("eng_a", eng_a, la);
          chk("eng_b", eng_b, lb);
          chk("start_pulse", prev_start, 0);
        end
        prev_start = eng_start;
        if (held && out_valid) begin
          chk("hold_gcd", out_gcd, hg);
          chk("hold_err", out_err, he);
        end
        held = out_valid && !out_ready;
        hg = out_gcd;
        he = out_err;
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) chk("spurious_result", 1, 0);
          else begin
            e = exp_q.pop_front();
            chk("out_gcd", out_gcd, e[31:0]);
            chk("out_err", out_err, e[32]);
          end
          got_q.push_back(out_gcd);
          exp_jobs = exp_jobs + 2'd1;
        end
      end
    end
  end

  task automatic send(input logic [31:0] a, input logic [31:0] b);
    int old = acc_cnt, n = 0;
    in_a = a;
    in_b = b;
    in_valid = 1'b1;
    do begin
      @(posedge clk); #1;
      n++;
    end while (acc_cnt == old && n < 200);
    if (acc_cnt == old) chk("accept_bound", 0, 1);
  endtask

  task automatic wait_ov(output int n);
    n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!(in_ready && !out_valid && exp_q.size() == 0) && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    chk("idle_bound", n < 300, 1);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_start", eng_start, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_err", out_err, 0);
    chk("rst_jobs", jobs_done, 0);
    chk("rst_gcd", out_gcd, 0);
    chk("rst_eng_a", eng_a, 0);
    chk("rst_eng_b", eng_b, 0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    chk("rst_ready_low", in_ready, 0);
    @(posedge clk); #1;
    chk("ready_after_rst", in_ready, 1);
  endtask

  initial begin
    int n, base;
    int wrap_exp[5] = '{1, 2, 3, 0, 1};
    do_reset();
    // basic job
    lat = 5;
    send(48, 18);
    in_valid = 1'b0;
    chk("basic_start", eng_start, 1);
    chk("basic_ready_low", in_ready, 0);
    wait_ov(n);
    chk("basic_latency", n, 6);
    wait_idle();
    chk("basic_gcd", got_q[$], 6);
    chk("basic_jobs", jobs_done, 1);
    // back-to-back with zero operands
    lat = 2;
    base = got_q.size();
    send(7, 0);
    chk("b2b_ready0", in_ready, 0);
    send(0, 9);
    chk("b2b_ready1", in_ready, 0);
    send(0, 0);
    chk("b2b_ready2", in_ready, 0);
    in_valid = 1'b0;
    wait_idle();
    chk("b2b_count", got_q.size() - base, 3);
    if (got_q.size() - base == 3) begin
      chk("b2b_r0", got_q[base], 7);
      chk("b2b_r1", got_q[base+1], 9);
      chk("b2b_r2", got_q[base+2], 0);
    end
    // backpressure
    out_ready = 1'b0;
    lat = 3;
    send(35, 14);
    in_a = 12;
    in_b = 8;
    base = acc_cnt;
    wait_ov(n);
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", out_valid, 1);
      chk("bp_gcd", out_gcd, 7);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    chk("bp_valid6", out_valid, 1);
    chk("bp_no_accept", acc_cnt, base);
    @(posedge clk); #1;
    chk("bp_released", out_valid, 0);
    send(12, 8);
    in_valid = 1'b0;
    wait_idle();
    chk("bp_next_gcd", got_q[$], 4);
    // timeout with a silent engine, then drain on a late pulse
    hang = 1;
    send(5, 10);
    in_valid = 1'b0;
    wait_ov(n);
    chk("to_latency", n, TO + 1);
    chk("to_err", out_err, 1);
    chk("to_gcd", out_gcd, 0);
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      chk("drain_ready", in_ready, 0);
      @(posedge clk); #1;
    end
    hang = 0;
    late_cnt++;
    n = 0;
    do begin
      @(posedge clk);
      n++;
    end while (!eng_done && n < 10);
    #1;
    chk("drain_exit", in_ready, 1);
    // done on the same edge as the timeout wins; one cycle later it lands in RESP
    lat = TO;
    send(21, 6);
    in_valid = 1'b0;
    wait_ov(n);
    chk("edge_latency", n, TO + 1);
    chk("edge_err", out_err, 0);
    wait_idle();
    lat = TO + 1;
    send(9, 6);
    in_valid = 1'b0;
    wait_ov(n);
    chk("late_err", out_err, 1);
    wait_idle();
    // reset mid-job
    lat = 12;
    send(100, 75);
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    do_reset();
    lat = 4;
    send(100, 75);
    in_valid = 1'b0;
    wait_idle();
    chk("rst_gcd_after", got_q[$], 25);
    chk("rst_jobs_after", jobs_done, 1);
    // counter wrap
    do_reset();
    for (int i = 0; i < 5; i++) begin
      lat = 1 + i;
      send(32'(6 * (i + 1)), 32'(4 * (i + 2)));
      in_valid = 1'b0;
      wait_idle();
      chk("wrap", jobs_done, wrap_exp[i]);
    end
    // randomized traffic with random backpressure and engine latency
    base = acc_cnt;
    n = base;
    lat = $urandom_range(1, TO + 3);
    in_a = $urandom_range(0, 40) * 6;
    in_b = $urandom_range(0, 40) * 6;
    repeat (1500) begin
      @(posedge clk); #1;
      out_ready = $urandom_range(0, 2) != 0;
      if (acc_cnt != n) begin
        int k = $urandom_range(1, 12);
        n = acc_cnt;
        lat = $urandom_range(1, TO + 3);
        in_a = ($urandom_range(0, 4) == 0) ? $urandom : 32'(k * $urandom_range(0, 40));
        in_b = ($urandom_range(0, 4) == 0) ? $urandom : 32'(k * $urandom_range(0, 40));
      end
      in_valid = $urandom_range(0, 3) != 0;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    wait_idle();
    chk("rand_jobs_seen", acc_cnt - base > 20, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1);
  end
endmodule
